adder_byte_seq: RTL and testbench
=================================

Name: adder_byte_seq

Overview:
Multi-byte add sequencer placed directly upstream of the team's combinational 8-bit adder (a, b, cin -> sum, cout). It accepts two NBYTES-wide operands and drives the adder one byte per clock, least-significant byte first. The adder's cout is registered and fed back as the next byte's cin. Sum bytes are collected into a wide result, and done pulses when the whole word is complete.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand (>=1); operand width W = 8*NBYTES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled when not in RUN
op_a  in  W  operand A, latched on accepted start
op_b  in  W  operand B, latched on accepted start
cin_init  in  1  carry into byte 0, latched on accepted start
add_a  out  8  to adder a
add_b  out  8  to adder b
add_cin  out  1  to adder cin
add_sum  in  8  from adder sum
add_cout  in  1  from adder cout
busy  out  1  high while in RUN
done  out  1  one-cycle pulse: result/carry_out valid
result  out  W  assembled sum; held until next accepted start
carry_out  out  1  final carry; held with result

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 immediately forces state=IDLE, idx=0, carry=0, latched operands=0, result=0, carry_out=0, done=0, busy=0.
- FSM states: IDLE, RUN, DONE. The byte index idx is sized to hold 0..NBYTES-1.
- IDLE: if start=1 at the edge, latch op_a, op_b, cin_init->carry; idx<=0; result<=0; carry_out<=0; go to RUN. Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - Combinational drive: add_a=A[8*idx+:8], add_b=B[8*idx+:8], add_cin=carry.
  - At each edge: result[8*idx+:8]<=add_sum; carry<=add_cout.
  - If idx==NBYTES-1: carry_out<=add_cout and go to DONE. Otherwise idx<=idx+1.
  - start is ignored in RUN; operands are not re-latched.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - If start=1 at the edge, it is accepted exactly as in IDLE and the next state is RUN (back-to-back). Otherwise go to IDLE.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- Latency: start accepted at edge E0; bytes captured at E1..EN; done is high in the cycle between EN and EN+1. busy is high for exactly NBYTES cycles.
- Widths: no truncation; the carry out of the top byte appears only on carry_out (unsigned overflow indicator).
- result and carry_out are stable from done until the next accepted start, which clears both.
- Reset mid-RUN aborts the operation: no done pulse, outputs return to reset values. A subsequent start behaves normally.
- NBYTES=1: RUN lasts one cycle, then DONE.
- The adder instance is external. This block makes no assumption about adder internals beyond combinational settling within one cycle.

Test Plan:
(All with NBYTES=4, the real adder instance, clk period 10.)
1. op_a=0x0000000F, op_b=0x0000000C, cin_init=1, start pulse -> result=0x0000001C, carry_out=0; done high exactly in cycle 5 after start edge; busy high for 4 cycles.
2. op_a=0xFFFFFFFF, op_b=0x00000001, cin_init=0 -> carry ripples through every byte; add_cin seen as 0,1,1,1 on successive RUN cycles; result=0x00000000, carry_out=1.
3. op_a=0xF34B6306, op_b=0x49C98909, cin_init=1 -> result=0x3D14EC10, carry_out=1; check add_a/add_b byte sequence 06/09, 63/89, 4B/C9, F3/49.
4. Start while busy: second start with op_a=0x11111111, op_b=0x22222222 pulsed two cycles into RUN -> ignored; only the first result is produced; no second done.
5. Reset mid-op: drop rst_n during the third RUN cycle -> result=0, busy=0, done never pulses. After release, op 0x00000003+0x00000009, cin 0 -> result 0x0000000C.
6. Back-to-back: start held high through the DONE cycle with new operands 0x80000000+0x80000000, cin 0 -> the first done pulses; the second op produces result=0x00000000, carry_out=1, with done exactly 5 cycles after the DONE-cycle edge.

Source files
------------

// File: rtl/adder_byte_seq.sv
// adder_byte_seq
// Feeds an external combinational 8-bit adder with one byte per clock,
// starting at the least-significant byte. The adder's carry is registered
// and fed back as the next byte's carry-in. Sum bytes are collected into a
// wide result, and done pulses for one cycle when the whole word is ready.

module adder_byte_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin_init,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out
);

  localparam int W    = 8 * NBYTES;
  // With a single byte the index needs no range, but still needs one bit.
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [W-1:0]      r_op_a;
  logic [W-1:0]      r_op_b;
  logic [W-1:0]      r_result;
  logic              r_carry_out;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_last;

  // Pick byte number idx out of a wide operand.
  function automatic logic [7:0] f_byte(input logic [W-1:0] v, input logic [IDXW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) begin
        b = v[8*k +: 8];
      end
    end
    return b;
  endfunction

  // A start is only honoured outside RUN; the operation in flight is never disturbed.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == IDX_LAST);

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_RUN);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Next-state selection: IDLE waits for start, RUN walks the bytes, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Adder drive: current byte pair plus the registered carry while running, zero otherwise.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = f_byte(r_op_a, r_idx);
      add_b   = f_byte(r_op_b, r_idx);
      add_cin = r_carry;
    end else begin
      add_a   = 8'h00;
      add_b   = 8'h00;
      add_cin = 1'b0;
    end
  end

  // Datapath: latch operands on accept, then capture one sum byte and the carry per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op_a      <= op_a;
            r_op_b      <= op_b;
            r_carry     <= cin_init;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_result[8*k +: 8] <= add_sum;
            end
          end
          r_carry <= add_cout;
          if (w_last) begin
            r_carry_out <= add_cout;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_adder_byte_seq.sv
// Directed bench for adder_byte_seq with NBYTES=4 and a behavioural 8-bit
// adder standing in for the external adder instance.

module tb_adder_byte_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cin_init;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic [8:0]  w_sum_wide;

  int n_checks = 0;
  int n_pass   = 0;

  adder_byte_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_init  (cin_init),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  // Combinational 8-bit adder the sequencer drives
  always_comb begin
    w_sum_wide = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    add_sum    = w_sum_wide[7:0];
    add_cout   = w_sum_wide[8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation with idle start; ends in the DONE cycle
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [3:0] exp_cins,
                        input logic [31:0] exp_res, input logic exp_co);
    op_a = a; op_b = b; cin_init = ci; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      check_eq({tag, "_done_low"}, 64'(done), 64'd0);
      check_eq({tag, "_add_a"}, 64'(add_a), 64'(a[8*i +: 8]));
      check_eq({tag, "_add_b"}, 64'(add_b), 64'(b[8*i +: 8]));
      check_eq({tag, "_add_cin"}, 64'(add_cin), 64'(exp_cins[i]));
      step();
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
    check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_carry_out"}, 64'(carry_out), 64'(exp_co));
    check_eq({tag, "_add_a_idle"}, 64'(add_a), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = 32'h0; op_b = 32'h0; cin_init = 1'b0;
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_carry_out", 64'(carry_out), 64'd0);
    check_eq("rst_add_cin", 64'(add_cin), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: small add with carry-in
    run_op("t1", 32'h0000000F, 32'h0000000C, 1'b1, 4'b0001, 32'h0000001C, 1'b0);
    step();
    check_eq("t1_done_one_cycle", 64'(done), 64'd0);
    check_eq("t1_result_held", 64'(result), 64'h1C);
    step();

    // 2: carry ripples through every byte
    run_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b1110, 32'h00000000, 1'b1);
    step();
    check_eq("t2_carry_held", 64'(carry_out), 64'd1);

    // 3: mixed bytes
    run_op("t3", 32'hF34B6306, 32'h49C98909, 1'b1, 4'b1001, 32'h3D14EC10, 1'b1);
    step();

    // 4: start while busy is ignored
    op_a = 32'h01020304; op_b = 32'h10203040; cin_init = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    op_a = 32'h11111111; op_b = 32'h22222222; cin_init = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t4_busy", 64'(busy), 64'd1);
    check_eq("t4_add_a_b2", 64'(add_a), 64'h02);
    check_eq("t4_add_b_b2", 64'(add_b), 64'h20);
    check_eq("t4_add_cin_b2", 64'(add_cin), 64'd0);
    step();
    check_eq("t4_add_a_b3", 64'(add_a), 64'h01);
    step();
    check_eq("t4_done", 64'(done), 64'd1);
    check_eq("t4_result", 64'(result), 64'h11223344);
    check_eq("t4_carry_out", 64'(carry_out), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t4_no_second_done", 64'(done), 64'd0);
      check_eq("t4_no_second_busy", 64'(busy), 64'd0);
    end
    check_eq("t4_result_held", 64'(result), 64'h11223344);

    // 5: reset during the third RUN cycle
    op_a = 32'h01010101; op_b = 32'h01010101; cin_init = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("t5_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_result_rst", 64'(result), 64'd0);
    check_eq("t5_busy_rst", 64'(busy), 64'd0);
    check_eq("t5_done_rst", 64'(done), 64'd0);
    check_eq("t5_carry_rst", 64'(carry_out), 64'd0);
    check_eq("t5_add_a_rst", 64'(add_a), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_no_done", 64'(done), 64'd0);
      check_eq("t5_idle_busy", 64'(busy), 64'd0);
    end
    run_op("t5b", 32'h00000003, 32'h00000009, 1'b0, 4'b0000, 32'h0000000C, 1'b0);
    step();

    // 6: back-to-back, start held through the DONE cycle
    op_a = 32'h00000001; op_b = 32'h00000002; cin_init = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    op_a = 32'h80000000; op_b = 32'h80000000; cin_init = 1'b0; start = 1'b1;
    check_eq("t6_add_a_b3", 64'(add_a), 64'h00);
    step();
    check_eq("t6_first_done", 64'(done), 64'd1);
    check_eq("t6_first_result", 64'(result), 64'h3);
    check_eq("t6_first_carry", 64'(carry_out), 64'd0);
    step();
    start = 1'b0;
    check_eq("t6_second_busy", 64'(busy), 64'd1);
    check_eq("t6_second_done_low", 64'(done), 64'd0);
    check_eq("t6_result_cleared", 64'(result), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_busy_run", 64'(busy), 64'd1);
      check_eq("t6_done_run", 64'(done), 64'd0);
    end
    check_eq("t6_add_a_top", 64'(add_a), 64'h80);
    check_eq("t6_add_b_top", 64'(add_b), 64'h80);
    step();
    check_eq("t6_second_done", 64'(done), 64'd1);
    check_eq("t6_second_result", 64'(result), 64'h0);
    check_eq("t6_second_carry", 64'(carry_out), 64'd1);
    step();
    check_eq("t6_done_pulse_end", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
